// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display.
// Segment codes are active-low, bit0=a through bit6=g.
package alu_result_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  localparam logic [6:0] SEG_TABLE [16] = '{
    SEG_ZERO, 7'h79, 7'h24, 7'h30,
    7'h19,    7'h12, 7'h02, 7'h78,
    7'h00,    7'h10, 7'h08, 7'h03,
    7'h46,    7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_BLANK     = 2'd0,
    ST_SHOW      = 2'd1,
    ST_BLINK_OFF = 2'd2
  } disp_state_e;

endpackage

// File: rtl/alu_result_display_hex7seg_decoder.sv
// Nibble to active-low 7-segment decoder.
// Purely combinational; reusable by other display stages.
module hex7seg_decoder
  import alu_result_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/alu_result_display.sv
// Captures the ALU result on a KEY press and shows it on two
// 7-segment digits, blinking while a captured overflow is set.
module alu_result_display
  import alu_result_display_pkg::*;
#(
  parameter int BLINK_DIV = 25000000,
  parameter int CNT_W     = 25
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       KEY_n,
  input  logic       clr,
  input  logic [7:0] result,
  input  logic       ovf,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic       OVF_LED,
  output logic       valid
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(BLINK_DIV - 1);

  disp_state_e      state_q;
  logic             s1_q;
  logic             s2_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic [6:0]       hex0_q;
  logic [6:0]       hex1_q;
  logic             ovf_q;
  logic             valid_q;
  logic             load;
  logic             cnt_done;
  logic [6:0]       seg_hi;
  logic [6:0]       seg_lo;

  assign load     = prev_q & ~s2_q;
  assign cnt_done = (cnt_q == CNT_MAX);
  assign data_d   = load ? result : data_q;

  hex7seg_decoder u_dec_hi (
    .nibble_i (data_d[7:4]),
    .seg_o    (seg_hi)
  );

  hex7seg_decoder u_dec_lo (
    .nibble_i (data_d[3:0]),
    .seg_o    (seg_lo)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      data_q  <= '0;
      hex0_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s1_q   <= KEY_n;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (clr) begin
        state_q <= ST_BLANK;
        cnt_q   <= '0;
        data_q  <= '0;
        hex0_q  <= SEG_BLANK;
        hex1_q  <= SEG_BLANK;
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end else if (load) begin
        state_q <= ST_SHOW;
        cnt_q   <= '0;
        data_q  <= data_d;
        hex0_q  <= seg_lo;
        hex1_q  <= seg_hi;
        ovf_q   <= ovf;
        valid_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_BLANK: begin
            cnt_q <= '0;
          end
          ST_SHOW: begin
            if (!ovf_q) begin
              cnt_q <= '0;
            end else if (cnt_done) begin
              cnt_q   <= '0;
              state_q <= ST_BLINK_OFF;
              hex0_q  <= SEG_BLANK;
              hex1_q  <= SEG_BLANK;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_BLINK_OFF: begin
            if (cnt_done) begin
              cnt_q   <= '0;
              state_q <= ST_SHOW;
              hex0_q  <= seg_lo;
              hex1_q  <= seg_hi;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            hex0_q  <= SEG_BLANK;
            hex1_q  <= SEG_BLANK;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign HEX0    = hex0_q;
  assign HEX1    = hex1_q;
  assign OVF_LED = ovf_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Randomized bench for alu_result_display against a
// cycle-level behavioural model of the display.
module tb_alu_result_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic       clr;
  logic [7:0] res;
  logic       ovf;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic       ovf_led;
  logic       vld;

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // model: key samples (front = most recent edge) and captured data
  bit         kh[$];
  bit         m_valid;
  bit         m_ovf;
  logic [7:0] m_data;
  int         m_age;

  alu_result_display #(.BLINK_DIV(DIV), .CNT_W(4)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .KEY_n    (key_n),
    .clr      (clr),
    .result   (res),
    .ovf      (ovf),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .OVF_LED  (ovf_led),
    .valid    (vld)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ld;
    if (!rst_n) begin
      kh = '{1'b1, 1'b1, 1'b1};
      m_valid = 0;
      m_ovf = 0;
      m_data = '0;
      m_age = 0;
    end else begin
      // press seen two edges ago after a release three edges ago
      ld = (kh[1] == 1'b0) && (kh[2] == 1'b1);
      kh.push_front(key_n);
      void'(kh.pop_back());
      if (clr) begin
        m_valid = 0;
        m_ovf = 0;
        m_data = '0;
        m_age = 0;
      end else if (ld) begin
        m_valid = 1;
        m_data = res;
        m_ovf = ovf;
        m_age = 0;
      end else if (m_valid) begin
        m_age++;
      end
    end
  endtask

  task automatic check_all();
    bit shown;
    logic [6:0] e0, e1;
    shown = m_valid && (!m_ovf || ((m_age / DIV) % 2 == 0));
    e0 = shown ? seg_ref[m_data[3:0]] : 7'h7F;
    e1 = shown ? seg_ref[m_data[7:4]] : 7'h7F;
    chk("HEX0", {1'b0, hex0}, {1'b0, e0});
    chk("HEX1", {1'b0, hex1}, {1'b0, e1});
    chk("OVF_LED", {7'b0, ovf_led}, {7'b0, m_ovf});
    chk("valid", {7'b0, vld}, {7'b0, m_valid});
    chk("zero_flag", {7'b0, hex0 == 7'h40 && hex1 == 7'h40},
        {7'b0, shown && m_data == 8'h00});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic press(logic [7:0] v, logic o, int hold);
    res = v;
    ovf = o;
    key_n = 1'b0;
    repeat (hold) tick();
    key_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    clr = 1'b0;
    res = '0;
    ovf = 1'b0;
    kh = '{1'b1, 1'b1, 1'b1};
    m_valid = 0;
    m_ovf = 0;
    m_data = '0;
    m_age = 0;
    tick();
    chk("rst_HEX0", {1'b0, hex0}, 8'h7F);
    chk("rst_valid", {7'b0, vld}, 8'h00);
    rst_n = 1'b1;
    repeat (3) tick();

    // zero result, then steady for 50 cycles
    press(8'h00, 1'b0, 3);
    chk("zero_HEX0", {1'b0, hex0}, 8'h40);
    chk("zero_HEX1", {1'b0, hex1}, 8'h40);
    repeat (50) tick();

    // digit decode, then new result with no press
    press(8'h3A, 1'b0, 4);
    chk("dec_HEX1", {1'b0, hex1}, 8'h30);
    chk("dec_HEX0", {1'b0, hex0}, 8'h08);
    res = 8'hF0;
    repeat (10) tick();

    // held key with changing result
    key_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      res = 8'($urandom);
      tick();
    end
    key_n = 1'b1;
    repeat (5) tick();

    // blink with zero result, then reload mid blink-off
    press(8'h00, 1'b1, 3);
    repeat (12) tick();
    press(8'h5C, 1'b1, 3);
    repeat (20) tick();

    // clr coincident with load edge
    res = 8'h77;
    key_n = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_HEX0", {1'b0, hex0}, 8'h7F);
    key_n = 1'b1;
    repeat (6) tick();

    // reset during blink-off with a press in flight
    press(8'h81, 1'b1, 3);
    repeat (5) tick();
    key_n = 1'b0;
    tick();
    rst_n = 1'b0;
    key_n = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();

    // random presses, gaps and clears
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(12, 0);
      for (int g = 0; g < gap; g++) begin
        res = 8'($urandom);
        ovf = 1'($urandom);
        clr = ($urandom_range(7, 0) == 0);
        tick();
      end
      clr = 1'b0;
      press(8'($urandom), 1'($urandom), $urandom_range(6, 3));
    end
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
